// File: rtl/tmec_serial_ctrl_pkg.sv
// tmec_serial_ctrl_pkg
// Shared types and helpers for the serial Berlekamp-Massey sequencer.
// Contents: sequencer state encoding, log2 width helper.
package tmec_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Bits needed to hold values 0..x-1; used for counter and L widths.
    function automatic int log2(input int x);
        return $clog2(x);
    endfunction

endpackage

// File: rtl/tmec_serial_ctrl_if.sv
// tmec_serial_ctrl_if
// Handshake and datapath-control bundle between the sequencer and its
// surroundings (syndrome stage, BM datapath, Chien search).
// master: sequencer side (drives busy/done/err_count and all strobes).
// slave : environment side (drives start and drnzero).
interface tmec_serial_ctrl_if
    import tmec_serial_ctrl_pkg::*;
#(
    parameter int T = 3
);
    localparam int LW = log2(2 * T + 1);

    logic          start;
    logic          drnzero;
    logic          busy;
    logic          done;
    logic [LW-1:0] err_count;
    logic          synpe;
    logic          snce;
    logic          bsel;
    logic          caLast;
    logic          cbBeg;
    logic          msmpe;
    logic          cce;
    logic          dringPe;
    logic          c0first;

    modport master (
        input  start, drnzero,
        output busy, done, err_count,
        output synpe, snce, bsel, caLast, cbBeg, msmpe, cce, dringPe, c0first
    );

    modport slave (
        output start, drnzero,
        input  busy, done, err_count,
        input  synpe, snce, bsel, caLast, cbBeg, msmpe, cce, dringPe, c0first
    );

endinterface

// File: rtl/tmec_serial_ctrl_iter_counter.sv
// tmec_serial_ctrl_iter_counter
// Phase (p = 0..M-1) / iteration (r = 1..T) counter pair for the serial
// BM sequencer.
// Ports: clk, reset (async, active-high), clear (load p=0, r=1),
//        adv (step one phase), r, last (p == M-1), term (r == T at last
//        phase), nxt_first/nxt_last/nxt_beg (flags for the value the
//        counter holds next cycle, so the caller can register strobes).
module tmec_serial_ctrl_iter_counter
    import tmec_serial_ctrl_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 3,
    localparam int PW = log2(M),
    localparam int RW = log2(T + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          adv,
    output logic [RW-1:0] r,
    output logic          last,
    output logic          term,
    output logic          nxt_first,
    output logic          nxt_last,
    output logic          nxt_beg
);
    localparam logic [PW-1:0] P_LAST = PW'(M - 1);
    localparam logic [RW-1:0] R_LAST = RW'(T);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic [PW-1:0] p, p_n;
    logic [RW-1:0] r_n;

    always_comb begin
        p_n = p;
        r_n = r;
        if (clear) begin
            p_n = '0;
            r_n = R_ONE;
        end else if (adv) begin
            if (p == P_LAST) begin
                p_n = '0;
                r_n = r + R_ONE;
            end else begin
                p_n = p + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
            r <= '0;
        end else begin
            p <= p_n;
            r <= r_n;
        end
    end

    assign last      = (p == P_LAST);
    assign term      = last && (r == R_LAST);
    assign nxt_first = (p_n == '0);
    assign nxt_last  = (p_n == P_LAST);
    assign nxt_beg   = (r_n == R_ONE);

endmodule

// File: rtl/tmec_serial_ctrl.sv
// tmec_serial_ctrl
// Sequencer for the serial Berlekamp-Massey error-locator datapath.
// On start it issues the load strobes, then T iterations of M bit-serial
// cycles, tracks the locator degree L, selects bsel from drnzero, and
// pulses done with the final L on err_count.
// Ports: clk, reset (async, active-high), bus (tmec_serial_ctrl_if.master).
// All outputs are registered; strobes for the next cycle are decoded from
// the counter's lookahead flags.
module tmec_serial_ctrl
    import tmec_serial_ctrl_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    tmec_serial_ctrl_if.master      bus
);
    localparam int LW = log2(2 * T + 1);
    localparam int RW = log2(T + 1);

    state_t        state;
    logic [LW-1:0] l_reg;
    logic [LW-1:0] err_q;
    logic          busy_q, done_q, synpe_q, snce_q, bsel_q, ca_last_q;
    logic          cb_beg_q, msmpe_q, cce_q, dring_pe_q, c0first_q;

    logic [RW-1:0] r;
    logic          last, term, nxt_first, nxt_last, nxt_beg;
    logic          cnt_clear, cnt_adv;

    assign cnt_clear = (state == S_LOAD);
    assign cnt_adv   = (state == S_ITER) && !term;

    tmec_serial_ctrl_iter_counter #(.M(M), .T(T)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .adv       (cnt_adv),
        .r         (r),
        .last      (last),
        .term      (term),
        .nxt_first (nxt_first),
        .nxt_last  (nxt_last),
        .nxt_beg   (nxt_beg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            l_reg      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            synpe_q    <= 1'b0;
            snce_q     <= 1'b0;
            bsel_q     <= 1'b0;
            ca_last_q  <= 1'b0;
            cb_beg_q   <= 1'b0;
            msmpe_q    <= 1'b0;
            cce_q      <= 1'b0;
            dring_pe_q <= 1'b0;
            c0first_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done_q     <= 1'b0;
            synpe_q    <= 1'b0;
            snce_q     <= 1'b0;
            ca_last_q  <= 1'b0;
            cb_beg_q   <= 1'b0;
            msmpe_q    <= 1'b0;
            cce_q      <= 1'b0;
            dring_pe_q <= 1'b0;
            c0first_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_LOAD;
                        synpe_q <= 1'b1;
                        snce_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD, S_ITER: begin
                    if (state == S_LOAD) begin
                        bsel_q <= bus.drnzero;
                        l_reg  <= bus.drnzero ? LW'(1) : '0;
                    end else if (last && !term) begin
                        // BM length update; the last iteration's discrepancy is unused.
                        if (bus.drnzero && (l_reg <= LW'(r))) begin
                            bsel_q <= 1'b1;
                            l_reg  <= (LW'(r) << 1) + LW'(1) - l_reg;
                        end else begin
                            bsel_q <= 1'b0;
                        end
                    end
                    if (state == S_ITER && term) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        err_q  <= l_reg;
                    end else begin
                        state      <= S_ITER;
                        cce_q      <= 1'b1;
                        msmpe_q    <= nxt_first;
                        dring_pe_q <= nxt_first;
                        c0first_q  <= nxt_first;
                        ca_last_q  <= nxt_last;
                        snce_q     <= nxt_last;
                        cb_beg_q   <= nxt_beg;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state   <= S_LOAD;
                        synpe_q <= 1'b1;
                        snce_q  <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_q;
    assign bus.synpe     = synpe_q;
    assign bus.snce      = snce_q;
    assign bus.bsel      = bsel_q;
    assign bus.caLast    = ca_last_q;
    assign bus.cbBeg     = cb_beg_q;
    assign bus.msmpe     = msmpe_q;
    assign bus.cce       = cce_q;
    assign bus.dringPe   = dring_pe_q;
    assign bus.c0first   = c0first_q;

endmodule

// File: tb/tb_tmec_serial_ctrl.sv
// tb_tmec_serial_ctrl
// Directed bench for tmec_serial_ctrl: M=4/T=3 instance for the scenario
// sequence, M=8/T=5 instance for the parameter sweep. Expected err_count
// values are queued when a run is started and popped when done appears.
module tb_tmec_serial_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tmec_serial_ctrl_if #(.T(3)) ifa ();
    tmec_serial_ctrl_if #(.T(5)) ifb ();

    tmec_serial_ctrl #(.M(4), .T(3)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    tmec_serial_ctrl #(.M(8), .T(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    bit bm = 1'b0;   // expected bsel
    int lm = 0;      // expected L

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {synpe,snce,bsel,caLast,cbBeg,msmpe,cce,dringPe,c0first,busy,done}
    function automatic logic [10:0] get_vec();
        return {ifa.synpe, ifa.snce, ifa.bsel, ifa.caLast, ifa.cbBeg, ifa.msmpe,
                ifa.cce, ifa.dringPe, ifa.c0first, ifa.busy, ifa.done};
    endfunction

    // Expected outputs for cycle c of a run (start sampled at cycle 0).
    function automatic logic [10:0] exp_vec(input int c, input bit b);
        bit iter, syn, ca, fst;
        int ph, rr;
        syn  = (c == 1);
        iter = (c >= 2) && (c <= 13);
        ph   = (c - 2) % 4;
        rr   = (c - 2) / 4 + 1;
        ca   = iter && (ph == 3);
        fst  = iter && (ph == 0);
        return {syn, syn || ca, b, ca, iter && (rr == 1), fst, iter, fst, fst,
                (c >= 1) && (c <= 14), c == 14};
    endfunction

    task automatic run(input string name, input bit skip_start,
                       input bit d0, input bit d5, input bit d9, input bit d13,
                       input bit st3, input bit st14, input int abort_at,
                       input int exp_err);
        bit drn;
        int rr;
        int dn;
        if (!skip_start) begin
            ifa.start = 1'b1;
            tick();
            ifa.start = 1'b0;
        end
        exp_q.push_back(exp_err);
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("%s_c%0d", name, c), 32'(get_vec()), 32'(exp_vec(c, bm)));
            if (ifa.done && exp_q.size() > 0)
                chk($sformatf("%s_err_count", name), 32'(ifa.err_count), 32'(exp_q.pop_front()));
            if (c == abort_at) begin
                reset = 1'b1;
                #1;
                chk($sformatf("%s_abort_outs", name), 32'(get_vec()), 32'd0);
                chk($sformatf("%s_abort_err", name), 32'(ifa.err_count), 32'd0);
                exp_q.delete();
                bm = 1'b0;
                lm = 0;
                ifa.drnzero = 1'b0;
                tick();
                tick();
                reset = 1'b0;
                dn = 0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    dn += int'(ifa.done);
                end
                chk($sformatf("%s_no_done", name), 32'(dn), 32'd0);
                return;
            end
            drn = (c == 1) ? d0 : (c == 5) ? d5 : (c == 9) ? d9 : (c == 13) ? d13 : 1'b0;
            ifa.drnzero = drn;
            ifa.start = (st3 && c == 3) || (st14 && c == 14);
            if (c == 1) begin
                bm = drn;
                lm = int'(drn);
            end else if (c == 5 || c == 9) begin
                rr = (c - 1) / 4;
                if (drn && lm <= rr) begin
                    bm = 1'b1;
                    lm = 2 * rr + 1 - lm;
                end else begin
                    bm = 1'b0;
                end
            end
            tick();
            ifa.start = 1'b0;
            ifa.drnzero = 1'b0;
        end
        if (!st14)
            chk($sformatf("%s_idle", name), 32'(get_vec()), 32'(exp_vec(15, bm)));
    endtask

    task automatic sweep();
        int c, n_ms, n_ca, n_cce;
        bit seen;
        c = 1; n_ms = 0; n_ca = 0; n_cce = 0; seen = 1'b0;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        while (c <= 60 && !seen) begin
            if (ifb.done) begin
                seen = 1'b1;
            end else begin
                n_ms  += int'(ifb.msmpe);
                n_ca  += int'(ifb.caLast);
                n_cce += int'(ifb.cce);
                tick();
                c++;
            end
        end
        chk("sweep_done_seen", 32'(seen), 32'd1);
        chk("sweep_done_cycle", 32'(c), 32'd42);
        chk("sweep_msmpe", 32'(n_ms), 32'd5);
        chk("sweep_caLast", 32'(n_ca), 32'd5);
        chk("sweep_cce", 32'(n_cce), 32'd40);
        chk("sweep_err_count", 32'(ifb.err_count), 32'd0);
        tick();
        chk("sweep_idle_busy", 32'(ifb.busy), 32'd0);
    endtask

    initial begin
        ifa.start = 1'b0;
        ifa.drnzero = 1'b0;
        ifb.start = 1'b0;
        ifb.drnzero = 1'b0;
        tick();
        tick();
        chk("reset_outs", 32'(get_vec()), 32'd0);
        chk("reset_err", 32'(ifa.err_count), 32'd0);
        reset = 1'b0;
        tick();

        run("zero",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run("single", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        run("two",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        run("busy1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        run("b2b",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        run("abort",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 2);
        run("after",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4);
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
